// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding req/gnt + rvalid read, valid/ready hand-off to decode.
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module instr_fetch #(
   parameter int          XLEN        = 32,
   parameter logic [31:0] HALT_INSTR  = 32'h00100073,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_reg,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr_out,
   output logic [XLEN-1:0] instr_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic            pc_advance,
   output logic            finish_flag,
   output logic            bus_err,
   output logic            fetch_fault
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_HOLD,
      S_DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   wait_cnt;
   logic               misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign misaligned = (pc_reg[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Request and address follow pc_reg combinationally so the PC may settle while gnt is pending.
   assign imem_req   = (state == S_REQ) && !misaligned;
   assign imem_addr  = (state == S_REQ) ? pc_reg : '0;
   assign pc_advance = instr_valid && instr_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         instr_out   <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         finish_flag <= 1'b0;
         bus_err     <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         case (state)
            S_IDLE: state <= S_REQ;

            S_REQ: begin
               if (misaligned) begin
                  fetch_fault <= 1'b1;
                  finish_flag <= 1'b1;
                  state       <= S_DONE;
               end else if (imem_gnt) begin
                  instr_pc <= pc_reg;
                  wait_cnt <= '0;
                  state    <= S_RESP;
               end
            end

            S_RESP: begin
               // rvalid takes priority over a timeout landing in the same cycle
               if (imem_rvalid) begin
                  instr_out <= imem_rdata;
                  wait_cnt  <= '0;
                  if (imem_rdata == HALT_INSTR) begin
                     finish_flag <= 1'b1;
                     state       <= S_DONE;
                  end else begin
                     instr_valid <= 1'b1;
                     state       <= S_HOLD;
                  end
               end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  bus_err     <= 1'b1;
                  finish_flag <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            S_HOLD: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= S_REQ;
               end
            end

            S_DONE: state <= S_DONE;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
